// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
// Carries the ovf flag only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half adders + OR form a full adder, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic s1, c1, s2, c2, carry_nxt;

    halfadder u_ha1 (.a(a_sh_q[0]), .b(b_sh_q[0]), .s(s1), .c(c1));
    halfadder u_ha2 (.a(s1),        .b(carry_q),   .s(s2), .c(c2));

    assign carry_nxt = c1 | c2;

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {s2, sum_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // On the last bit carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random adds
// compared against an arithmetic reference model.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction; inj > 0 re-asserts start (a=AA) at that SHIFT cycle,
    // hit_done asserts start while done is high. Both must be ignored.
    task automatic do_add(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input int inj, input bit hit_done);
        logic [WIDTH:0] exp_full;
        int lat;
        int busy_cnt;
        exp_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 4 * WIDTH) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (lat == inj) begin
                bus.start = 1'b1; bus.a = 8'hAA; bus.b = WIDTH'($urandom); bus.cin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, " sum"}, 64'(bus.sum), 64'(exp_full[WIDTH-1:0]));
        check({tag, " cout"}, 64'(bus.cout), 64'(exp_full[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, 64'(bus.ovf),
              64'((a[WIDTH-1] == b[WIDTH-1]) && (exp_full[WIDTH-1] != a[WIDTH-1])));
`endif
        if (hit_done) begin
            bus.start = 1'b1; bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'(0));
        check({tag, " idle_after"}, 64'(bus.busy), 64'(0));
        check({tag, " sum_held"}, 64'(bus.sum), 64'(exp_full[WIDTH-1:0]));
    endtask

    initial begin
        int done_seen;
        logic [WIDTH-1:0] ra, rb;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Reset held for two cycles
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset sum", 64'(bus.sum), 64'(0));
        check("reset cout", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", 64'(bus.ovf), 64'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        do_add("basic", 8'h35, 8'h4A, 1'b0, 0, 1'b0);
        check("basic literal", 64'(bus.sum), 64'h7F);
        do_add("wrap1", 8'hFF, 8'h00, 1'b1, 0, 1'b0);
        check("wrap1 literal", 64'({bus.cout, bus.sum}), 64'h100);
        do_add("wrap2", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        check("wrap2 literal", 64'({bus.cout, bus.sum}), 64'h1FF);

        // Start while busy, then start while done
        do_add("busy_start", 8'h01, 8'h01, 1'b0, 3, 1'b0);
        check("busy_start literal", 64'(bus.sum), 64'h02);
        do_add("done_start", 8'h12, 8'h34, 1'b1, 0, 1'b1);

        // Reset in the middle of SHIFT aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset busy", 64'(bus.busy), 64'(0));
        check("midreset sum", 64'(bus.sum), 64'(0));
        check("midreset done", 64'(bus.done), 64'(0));
        rst_n = 1'b1;
        done_seen = 0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("midreset no_done", 64'(done_seen), 64'(0));
        do_add("after_reset", 8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Signed-overflow corner operands
        do_add("ovf1", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_add("ovf2", 8'h80, 8'h80, 1'b0, 0, 1'b0);
        do_add("ovf3", 8'h05, 8'h03, 1'b0, 0, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf3 literal", 64'(bus.ovf), 64'(0));
`endif

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_add("random", ra, rb, 1'($urandom), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
